// File: rtl/dm_sub_if.sv
// Request/response bundle between the MEM stage and dm_sub, plus the
// store-trace tap that a simulation-side printer turns into the trace line.
interface dm_sub_if;
    logic [31:0] PC;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] A;
    logic [31:0] DI;
    logic        ready;
    logic [31:0] DO;
    logic        rvalid;
    logic        exc;
    logic        busy;
    logic        trace_fire;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_word;

    modport master (
        output PC, req, we, size, sign_ext, A, DI,
        input  ready, DO, rvalid, exc, busy,
        input  trace_fire, trace_pc, trace_addr, trace_word
    );

    modport slave (
        input  PC, req, we, size, sign_ext, A, DI,
        output ready, DO, rvalid, exc, busy,
        output trace_fire, trace_pc, trace_addr, trace_word
    );
endinterface

// File: rtl/dm_sub.sv
// Single-port data memory: sub-word stores with lane merge, extended sub-word
// loads through a two-stage read path, fault reporting and a post-reset clear.
module dm_sub #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          LOG_EN     = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    dm_sub_if.slave  bus
);
    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    // Accepted access, captured at the accepting edge with its raw word.
    typedef struct packed {
        logic        vld;
        logic        load;
        logic        fault;
        logic        sign;
        logic [1:0]  size;
        logic [1:0]  lane;
        logic [31:0] word;
    } s1_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    s1_t                   s1_q, s1_d;
    logic                  rvalid_q, rvalid_d;
    logic                  exc_q, exc_d;
    logic [31:0]           do_q, do_d;

    logic [31:0]           mem_q [DEPTH];

    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            lane;
    logic                  accept;
    logic                  fault;
    logic [31:0]           rd_word;
    logic [31:0]           mask;
    logic [31:0]           merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           shifted;
    logic [15:0]           half;
    logic [31:0]           ext;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        off     = bus.A - BASE_ADDR;
        widx    = off[ADDR_WIDTH+1:2];
        lane    = off[1:0];
        accept  = (state_q == ST_READY) && bus.req;
        fault   = ({1'b0, off} >= SPAN)
                || (bus.size == 2'b11)
                || ((bus.size == 2'b01) && bus.A[0])
                || ((bus.size == 2'b10) && (bus.A[1:0] != 2'b00));
        rd_word = mem_q[widx];
        mask    = 32'hFFFF_FFFF;
        merged  = bus.DI;
        case (bus.size)
            2'b00: begin
                mask   = 32'h0000_00FF << {lane, 3'b000};
                merged = (rd_word & ~mask) | ({4{bus.DI[7:0]}} & mask);
            end
            2'b01: begin
                mask   = bus.A[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                merged = (rd_word & ~mask) | ({2{bus.DI[15:0]}} & mask);
            end
            default: merged = bus.DI;
        endcase
    end

    // Clear engine owns the write port until it reaches the last word.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_addr  = widx;
        mem_wdata = merged;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_idx_q;
                mem_wdata = 32'h0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (&clr_idx_q) state_d = ST_READY;
            end
            ST_READY: begin
                mem_we = accept && bus.we && !fault;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        s1_d       = '0;
        s1_d.vld   = accept;
        s1_d.load  = !bus.we;
        s1_d.fault = fault;
        s1_d.sign  = bus.sign_ext;
        s1_d.size  = bus.size;
        s1_d.lane  = lane;
        s1_d.word  = rd_word;
    end

    always_comb begin
        shifted = s1_q.word >> {s1_q.lane, 3'b000};
        half    = s1_q.lane[1] ? s1_q.word[31:16] : s1_q.word[15:0];
        case (s1_q.size)
            2'b00:   ext = {{24{s1_q.sign & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{s1_q.sign & half[15]}}, half};
            default: ext = s1_q.word;
        endcase
        rvalid_d = s1_q.vld && s1_q.load;
        exc_d    = s1_q.vld && s1_q.fault;
        do_d     = do_q;
        if (rvalid_d) do_d = s1_q.fault ? 32'h0 : ext;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            s1_q      <= '0;
            rvalid_q  <= 1'b0;
            exc_q     <= 1'b0;
            do_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            s1_q      <= s1_d;
            rvalid_q  <= rvalid_d;
            exc_q     <= exc_d;
            do_q      <= do_d;
        end
    end

    // NOTE: the array has no reset; an async reset on every word would
    // prevent RAM mapping, and the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
    end

    assign bus.ready      = (state_q == ST_READY);
    assign bus.busy       = (state_q == ST_CLEAR);
    assign bus.DO         = do_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.exc        = exc_q;
    assign bus.trace_fire = LOG_EN && accept && bus.we && !fault;
    assign bus.trace_pc   = bus.PC;
    assign bus.trace_addr = {bus.A[31:2], 2'b00};
    assign bus.trace_word = merged;
endmodule

// File: tb/tb_dm_sub.sv
// Self-checking bench for dm_sub (ADDR_WIDTH=4): vector table through a
// cycle-exact scoreboard, plus clear, pipelining and reset sequences.
module tb_dm_sub;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dm_sub_if bus();

    dm_sub #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .LOG_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        ex;
        logic [31:0] dout;
        int          due;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        logic        rv;
        logic        ex;
        logic [31:0] dout;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] tr_addr[$];
    logic [31:0] tr_word[$];
    int          cyc     = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_trace = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.trace_fire) begin
            $display("%d@%h: *%h <= %h", $time, bus.trace_pc, bus.trace_addr, bus.trace_word);
            n_trace++;
            tr_addr.push_back(bus.trace_addr);
            tr_word.push_back(bus.trace_word);
        end
    end

    // Every expected strobe is due at an exact cycle; any other strobe is stray.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check({e.name, " rvalid"}, 32'(bus.rvalid), 32'(e.rv));
            check({e.name, " exc"}, 32'(bus.exc), 32'(e.ex));
            if (e.rv) check({e.name, " DO"}, bus.DO, e.dout);
        end else begin
            check("stray strobe", {30'b0, bus.rvalid, bus.exc}, 32'h0);
        end
    end

    task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic rv, input logic ex, input logic [31:0] dout);
        exp_t e;
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.A        = a;
        bus.DI       = d;
        bus.PC       = 32'h0000_0400 + a;
        if (rv || ex) begin
            e.rv = rv; e.ex = ex; e.dout = dout; e.due = cyc + 2; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.A = 32'h0; bus.DI = 32'h0; bus.PC = 32'h0;
        #1 reset = 1'b0;
        #1;
        check("reset ready", 32'(bus.ready), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h1);
        check("reset rvalid/exc", {30'b0, bus.rvalid, bus.exc}, 32'h0);
        check("reset DO", bus.DO, 32'h0);
        for (int i = 0; i < DEPTH; i++) dut.mem_q[i] <= 32'hBAD0_0000 | 32'(i);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n);
        check("clear cycles", 32'(n), 32'(DEPTH));
        check("busy after clear", 32'(bus.busy), 32'h0);
        for (int i = 0; i < DEPTH; i++)
            issue("zero readback", 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'h0);
        drain();

        tbl.push_back('{"sw 8",        1'b1, 2'b10, 1'b0, 32'h08, 32'h1122_3344, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{"sb A",        1'b1, 2'b00, 1'b0, 32'h0A, 32'h0000_00AB, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{"lb A",        1'b0, 2'b00, 1'b1, 32'h0A, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFAB});
        tbl.push_back('{"lbu A",       1'b0, 2'b00, 1'b0, 32'h0A, 32'h0,         1'b1, 1'b0, 32'h0000_00AB});
        tbl.push_back('{"lw 8",        1'b0, 2'b10, 1'b0, 32'h08, 32'h0,         1'b1, 1'b0, 32'h11AB_3344});
        tbl.push_back('{"lb 8",        1'b0, 2'b00, 1'b1, 32'h08, 32'h0,         1'b1, 1'b0, 32'h0000_0044});
        tbl.push_back('{"lb B",        1'b0, 2'b00, 1'b1, 32'h0B, 32'h0,         1'b1, 1'b0, 32'h0000_0011});
        tbl.push_back('{"lh 8",        1'b0, 2'b01, 1'b1, 32'h08, 32'h0,         1'b1, 1'b0, 32'h0000_3344});
        tbl.push_back('{"sh 12",       1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{"lh 12",       1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         1'b1, 1'b0, 32'hFFFF_8001});
        tbl.push_back('{"lhu 12",      1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         1'b1, 1'b0, 32'h0000_8001});
        tbl.push_back('{"lw 10",       1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 32'h8001_0000});
        tbl.push_back('{"lh 10",       1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         1'b1, 1'b0, 32'h0000_0000});
        tbl.push_back('{"sb 0",        1'b1, 2'b00, 1'b0, 32'h00, 32'h0000_0180, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{"lb 0",        1'b0, 2'b00, 1'b1, 32'h00, 32'h0,         1'b1, 1'b0, 32'hFFFF_FF80});
        tbl.push_back('{"sw 3C",       1'b1, 2'b10, 1'b0, 32'h3C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{"lw 3C",       1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D});
        tbl.push_back('{"lbu 3F",      1'b0, 2'b00, 1'b0, 32'h3F, 32'h0,         1'b1, 1'b0, 32'h0000_00CA});
        tbl.push_back('{"lw 6 fault",  1'b0, 2'b10, 1'b0, 32'h06, 32'h0,         1'b1, 1'b1, 32'h0});
        tbl.push_back('{"sh 3 fault",  1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{"sz11 st",     1'b1, 2'b11, 1'b0, 32'h08, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{"sz11 ld",     1'b0, 2'b11, 1'b0, 32'h08, 32'h0,         1'b1, 1'b1, 32'h0});
        tbl.push_back('{"lw 40 fault", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,         1'b1, 1'b1, 32'h0});
        tbl.push_back('{"sb 40 fault", 1'b1, 2'b00, 1'b0, 32'h40, 32'h0000_00EE, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{"lw 8 again",  1'b0, 2'b10, 1'b0, 32'h08, 32'h0,         1'b1, 1'b0, 32'h11AB_3344});
        tbl.push_back('{"lw 0 again",  1'b0, 2'b10, 1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 32'h0000_0080});
        tbl.push_back('{"lw 3C again", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D});
        foreach (tbl[i])
            issue(tbl[i].name, tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d,
                  tbl[i].rv, tbl[i].ex, tbl[i].dout);
        drain();
        check("trace count", 32'(n_trace), 32'd5);
        if (tr_addr.size() >= 2) begin
            check("trace sb addr", tr_addr[1], 32'h0000_0008);
            check("trace sb word", tr_word[1], 32'h11AB_3344);
        end
        check("DO holds", bus.DO, 32'hCAFE_F00D);

        issue("pipe sw 20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        issue("pipe lw 20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        issue("pipe lw 24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 32'h0000_0000);
        drain();

        // Load in flight when reset hits: its strobe must never appear.
        issue("dropped lw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
        idle();
        reset = 1'b0;
        @(negedge clk);
        check("drop rvalid/exc", {30'b0, bus.rvalid, bus.exc}, 32'h0);
        check("drop DO", bus.DO, 32'h0);
        reset = 1'b1;
        wait_ready(n);
        check("clear after drop", 32'(n), 32'(DEPTH));
        issue("lw 20 cleared", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
        drain();

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        while (dut.clr_idx_q != 4'd5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reached index 5", 32'(dut.clr_idx_q), 32'd5);
        reset = 1'b0;
        #1;
        check("index restart", 32'(dut.clr_idx_q), 32'd0);
        check("busy in reset", 32'(bus.busy), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n);
        check("clear after mid-clear reset", 32'(n), 32'(DEPTH));
        issue("lw 8 cleared", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 1'b0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_sub.md
# dm_sub

Parametrised single-port data memory that succeeds the fixed 4096-word word-only data memory in the pipeline's MEM stage. It adds byte/halfword/word stores with lane merging, sign- or zero-extended sub-word loads, a registered read path with a valid strobe, alignment and range fault reporting, and a sequential clear engine that zeroes the array after reset. The store trace line is identical in format to the existing data memory, so the grading harness keeps working unchanged.

## Interface
- ADDR_WIDTH, 12, word-address bits; depth DEPTH = 2^ADDR_WIDTH words of 32 bits.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- LOG_EN, 1, when 1, every committed store emits the trace line.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- PC  in  32  PC of the requesting instruction; used for the trace only.
- req  in  1  access request, valid for one cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- A  in  32  byte address.
- DI  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  high when a request can be accepted.
- DO  out  32  load result, extended to 32 bits.
- rvalid  out  1  one-cycle strobe: DO is valid.
- exc  out  1  one-cycle strobe: the accepted access faulted.
- busy  out  1  clear engine running.

## Operation
- States: CLEAR and READY. Asserting reset forces CLEAR with clear index 0, regardless of current state, including mid-clear.
- CLEAR: each edge writes 0 to word[index], then increments index. After writing word DEPTH-1, the next state is READY. While in CLEAR, busy=1, ready=0, and req is ignored.
- READY: ready=1, busy=0. An access is accepted when req is high on an edge.
- Offset off = A - BASE_ADDR (32-bit, unsigned). Word index = off[ADDR_WIDTH+1:2]. Lane = off[1:0].
- Fault conditions: off >= 4*DEPTH; size=11; half with A[0]=1; word with A[1:0]!=0. A faulting access performs no write and emits no trace. It sets exc=1 at T+1, and for a load also rvalid=1 with DO=0.
- Store: merge DI into the addressed lane(s) of the existing word. Byte goes to lane*8. Half goes to [15:0] when A[1]=0, or [31:16] when A[1]=1. Word replaces the full word. The write commits on the accepting edge.
- Trace (LOG_EN=1, committed store only): "%d@%h: *%h <= %h" with $time, PC, the word-aligned byte address {A[31:2],2'b00}, and the merged 32-bit word.
- Load: the addressed word is read at the accepting edge. The lane is selected, extended per sign_ext, and registered into DO.
- Read-after-write: a load accepted one cycle after a store to the same word returns the merged value.
- DO holds its last value when rvalid=0.
- Stores never assert rvalid.

## Timing
- Reset values: ready=0, busy=1, rvalid=0, exc=0, DO=0, state CLEAR, index 0. Memory contents are not reset asynchronously; the clear engine zeroes them.
- Clear: ready rises after exactly DEPTH rising edges following reset deassertion.
- Throughput: one access per cycle in READY, with no back-pressure.
- Load latency: request accepted at edge T; DO and rvalid are valid after edge T+1, for one cycle.
- Store: array updated at edge T; exc (if any) is asserted after edge T+1 for one cycle.
- Back-to-back loads produce rvalid high on consecutive cycles.
- Reset asserted mid-access: the pending rvalid/exc is dropped, and the clear restarts from index 0.

## Test plan
- ADDR_WIDTH=4: preload garbage via hierarchy, pulse reset low, release. Required: busy=1 for 16 cycles, ready=1 on cycle 16, and every word reads 0.
- Byte store: sw 0x11223344 @0x8, then sb DI=0xAB @0xA. Required: trace shows "*00000008 <= 11ab3344". Then lb @0xA gives 0xFFFFFFAB; lbu @0xA gives 0x000000AB.
- Halfword: sh DI=0x8001 @0x12. Required: lh @0x12 gives 0xFFFF8001; lhu gives 0x00008001; lw @0x10 gives 0x80010000.
- Faults: lw @0x6, sh @0x3, size=11, and lw @4*DEPTH. Required: each gives exc=1 for one cycle. Loads give rvalid=1 with DO=0. Memory is unchanged and no trace is printed.
- Pipelined: sw 0xDEADBEEF @0x20 in cycle n, lw @0x20 in cycle n+1, lw @0x24 in cycle n+2. Required: rvalid in cycles n+2 and n+3, with DO = 0xDEADBEEF then 0x00000000.
- Reset mid-clear: assert reset at clear index 5, release. Required: the clear restarts at 0 and ready rises DEPTH cycles after the release.
